// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply,
// restoring divide, sign fix-up in a final cycle, MTHI/MTLO writes.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        div_q, div_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;

  logic        in_signed;
  logic        in_div;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        accept;
  logic        in_dz;

  always_comb begin
    in_signed = ~op[0];
    in_div    = op[1];
    a_neg     = in_signed & op_a[31];
    b_neg     = in_signed & op_b[31];
    a_mag     = a_neg ? (32'd0 - op_a) : op_a;
    b_mag     = b_neg ? (32'd0 - op_b) : op_b;
    accept    = (state_q == S_IDLE) & start & ~flush;
    in_dz     = in_div & (op_b == 32'd0);
  end

  // acc holds {product} for multiply and {remainder, quotient} for divide
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_sh;
  logic [32:0] div_diff;
  logic [63:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]}
             + {1'b0, acc_q[0] ? opnd_q : 32'd0};
    mul_next = {mul_sum, acc_q[31:1]};
    div_sh   = {acc_q[63:32], acc_q[31]};
    div_diff = div_sh - {1'b0, opnd_q};
    if (div_diff[32]) begin
      div_next = {div_sh[31:0], acc_q[30:0], 1'b0};
    end else begin
      div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
    end
  end

  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    prod_fix = neg_q ? (64'd0 - acc_q) : acc_q;
    quo_fix  = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem_fix  = rneg_q ? (32'd0 - acc_q[63:32])
                      : acc_q[63:32];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_dz) begin
            done_d = 1'b1;
            dz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            cnt_d   = 6'd0;
            div_d   = in_div;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg & in_div;
            opnd_d  = in_div ? b_mag : a_mag;
            acc_d   = {32'd0, in_div ? a_mag : b_mag};
          end
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = div_q ? div_next : mul_next;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      acc_q   <= 64'd0;
      opnd_q  <= 32'd0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: countdown/arithmetic reference model checked
// every cycle, plus literal results for the directed cases.
module tb_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .op_a     (op_a),
    .op_b     (op_b),
    .flush    (flush),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] dv,
                     input logic [31:0] mv, input logic [31:0] exp);
    cmp({nm, "_dut"}, dv, exp);
    cmp({nm, "_mdl"}, mv, exp);
  endtask

  function automatic logic [63:0] golden(input logic [1:0] o,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r, p;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin
        p   = sa * sb;
        res = p;
      end
      2'b01: res = {32'd0, a} * {32'd0, b};
      2'b10: begin
        q   = sa / sb;
        r   = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      default: res = {a % b, a / b};
    endcase
    return res;
  endfunction

  // Reference: remaining busy cycles, HI/LO, and the pending result.
  int          m_rem;
  logic [31:0] m_hi, m_lo;
  logic        m_done, m_dz;
  logic [63:0] m_res;

  always @(posedge clk) begin
    if (rst) begin
      m_rem  <= 0;
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      if (m_rem == 0) begin
        if (start && !flush) begin
          if (op[1] && op_b == 32'd0) begin
            m_done <= 1'b1;
            m_dz   <= 1'b1;
          end else begin
            m_rem <= 33;
            m_res <= golden(op, op_a, op_b);
          end
        end else begin
          if (hi_we) m_hi <= wdata;
          if (lo_we) m_lo <= wdata;
        end
      end else if (flush) begin
        m_rem <= 0;
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy", 32'(busy), 32'(m_rem != 0));
      cmp("done", 32'(done), 32'(m_done));
      cmp("div_zero", 32'(div_zero), 32'(m_dz));
      cmp("hi", hi, m_hi);
      cmp("lo", lo, m_lo);
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    #1;
    start = 1'b1;
    op    = o;
    op_a  = a;
    op_b  = b;
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic mt(input logic h, input logic l,
                    input logic [31:0] d);
    #1;
    hi_we = h;
    lo_we = l;
    wdata = d;
    @(negedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(output int bcnt);
    bit got;
    got  = done;
    bcnt = busy ? 1 : 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else if (busy) bcnt++;
    end
    if (!got) cmp("done_timeout", 32'd0, 32'd1);
  endtask

  int bc;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    op_a  = 32'd0;
    op_b  = 32'd0;
    flush = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = 32'd0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    lit("rst_hi", hi, m_hi, 32'd0);
    lit("rst_lo", lo, m_lo, 32'd0);
    cmp("rst_busy", 32'(busy), 32'd0);

    mt(1'b1, 1'b1, 32'hA5A5_0001);
    lit("mt_both_hi", hi, m_hi, 32'hA5A5_0001);
    lit("mt_both_lo", lo, m_lo, 32'hA5A5_0001);

    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(bc);
    cmp("mult_busy_cycles", 32'(bc), 32'd33);
    lit("mult_hi", hi, m_hi, 32'hFFFF_FFFF);
    lit("mult_lo", lo, m_lo, 32'hFFFF_FFEB);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(bc);
    lit("multu_hi", hi, m_hi, 32'hFFFF_FFFE);
    lit("multu_lo", lo, m_lo, 32'h0000_0001);

    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(bc);
    lit("div_hi", hi, m_hi, 32'hFFFF_FFFF);
    lit("div_lo", lo, m_lo, 32'hFFFF_FFFD);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(bc);
    lit("divmin_hi", hi, m_hi, 32'd0);
    lit("divmin_lo", lo, m_lo, 32'h8000_0000);

    issue(2'b11, 32'd7, 32'd0);
    wait_done(bc);
    cmp("dz_flag", 32'(div_zero), 32'd1);
    cmp("dz_busy_cycles", 32'(bc), 32'd0);
    lit("dz_hi", hi, m_hi, 32'd0);
    lit("dz_lo", lo, m_lo, 32'h8000_0000);
    @(negedge clk);

    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    issue(2'b11, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    #1 flush = 1'b0;
    cmp("flush_busy", 32'(busy), 32'd0);
    lit("flush_hi", hi, m_hi, 32'h11);
    lit("flush_lo", lo, m_lo, 32'h22);
    repeat (3) @(negedge clk);
    issue(2'b11, 32'd100, 32'd3);
    wait_done(bc);
    lit("divu_hi", hi, m_hi, 32'd1);
    lit("divu_lo", lo, m_lo, 32'd33);

    #1;
    start = 1'b1;
    op    = 2'b00;
    op_a  = 32'd5;
    op_b  = 32'd6;
    hi_we = 1'b1;
    wdata = 32'h1234;
    @(negedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    hi_we = 1'b1;
    wdata = 32'h5555;
    @(negedge clk);
    #1 hi_we = 1'b0;
    wait_done(bc);
    lit("startwin_hi", hi, m_hi, 32'd0);
    lit("startwin_lo", lo, m_lo, 32'd30);

    #1;
    start = 1'b1;
    flush = 1'b1;
    op    = 2'b11;
    op_a  = 32'd9;
    op_b  = 32'd2;
    @(negedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    cmp("idle_flush_busy", 32'(busy), 32'd0);
    @(negedge clk);

    issue(2'b01, 32'd3, 32'd4);
    wait_done(bc);
    lit("b2b1_lo", lo, m_lo, 32'd12);
    issue(2'b11, 32'd12, 32'd5);
    wait_done(bc);
    cmp("b2b_busy_cycles", 32'(bc), 32'd33);
    lit("b2b2_hi", hi, m_hi, 32'd2);
    lit("b2b2_lo", lo, m_lo, 32'd2);

    issue(2'b01, 32'd2, 32'd3);
    repeat (32) @(negedge clk);
    cmp("fix_busy", 32'(busy), 32'd1);
    #1 flush = 1'b1;
    @(negedge clk);
    #1 flush = 1'b0;
    cmp("fixflush_done", 32'(done), 32'd0);
    lit("fixflush_hi", hi, m_hi, 32'd2);
    lit("fixflush_lo", lo, m_lo, 32'd2);
    repeat (2) @(negedge clk);

    issue(2'b00, 32'd7, 32'd9);
    repeat (19) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    cmp("rst_mid_busy", 32'(busy), 32'd0);
    lit("rst_mid_hi", hi, m_hi, 32'd0);
    lit("rst_mid_lo", lo, m_lo, 32'd0);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    issue(2'b01, 32'd9, 32'd9);
    wait_done(bc);
    lit("post_rst_lo", lo, m_lo, 32'd81);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
